// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared bus definitions used by the bus arbiter slice.
//   BUS_MASTER_CNT    : default number of bus masters
//   BUS_OWNER_BUS     : width of the owner index (clog2 of BUS_MASTER_CNT)
//   bus_arb_state_e   : arbiter FSM state encodings
//   ENABLE_/DISABLE_  : levels for active-low bus control lines
package bus_arbiter_pkg;

  localparam int BUS_MASTER_CNT = 4;
  localparam int BUS_OWNER_BUS  = 2;

  typedef enum logic {
    BUS_ARB_STATE_IDLE  = 1'b0,
    BUS_ARB_STATE_GRANT = 1'b1
  } bus_arb_state_e;

  // Active-low control levels: a line is "enabled" when driven low.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/bus_arb_rr_pick.sv
// bus_arb_rr_pick: combinational rotating-priority picker.
//   req   : active-high request vector
//   ptr   : index with highest priority this cycle
//   excl  : masters removed from consideration
//   found : some non-excluded request exists
//   index : first eligible requester at or above ptr, wrapping modulo N
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int N = BUS_MASTER_CNT,
  parameter int W = BUS_OWNER_BUS
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic [N-1:0] excl,
  output logic         found,
  output logic [W-1:0] index
);

  logic [W-1:0] idx;

  // Scan from the farthest offset down to zero so the nearest eligible
  // requester to ptr is the last one written. N is a power of two, so the
  // W-bit add wraps exactly modulo N.
  always_comb begin
    found = 1'b0;
    index = ptr;
    idx   = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = ptr + W'(off);
      if (req[idx] && !excl[idx]) begin
        found = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for the shared system bus.
//   clk       : single clock, rising-edge state updates
//   reset     : synchronous active-high reset
//   Req_      : per-master request, active low
//   Grnt_     : per-master grant, active low, registered, at most one low
//   Owner     : current or most recent grantee, selects the bus mux
//   BusBusy   : high while any grant is asserted (registered with Grnt_)
//   HoldErr   : sticky flag, set when one grant lasts HOLD_MAX cycles
//   HoldErrId : owner that first raised HoldErr
// A grant is held until its owner releases; on release the next requester
// (rotating from the master after the last grantee) is granted on the same
// edge, with no idle cycle in between. Every output is a register.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MASTER_CNT = BUS_MASTER_CNT,
  parameter int OWNER_W    = BUS_OWNER_BUS,
  parameter int HOLD_MAX   = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MASTER_CNT-1:0] Req_,
  output logic [MASTER_CNT-1:0] Grnt_,
  output logic [OWNER_W-1:0]    Owner,
  output logic                  BusBusy,
  output logic                  HoldErr,
  output logic [OWNER_W-1:0]    HoldErrId
);

  localparam logic [15:0] HOLD_LIM = 16'(HOLD_MAX);

  bus_arb_state_e        state_r, state_n;
  logic [OWNER_W-1:0]    ptr_r, ptr_n;
  logic [15:0]           cnt_r, cnt_n;
  logic [MASTER_CNT-1:0] grnt_n;
  logic [OWNER_W-1:0]    owner_n, err_id_n;
  logic                  busy_n, err_n;

  logic [MASTER_CNT-1:0] excl;
  logic                  pick_found;
  logic [OWNER_W-1:0]    pick_idx;
  logic                  owner_req;

  bus_arb_rr_pick #(
    .N (MASTER_CNT),
    .W (OWNER_W)
  ) u_pick (
    .req   (~Req_),
    .ptr   (ptr_r),
    .excl  (excl),
    .found (pick_found),
    .index (pick_idx)
  );

  assign owner_req = (Req_[Owner] == ENABLE_);

  always_comb begin
    state_n  = state_r;
    ptr_n    = ptr_r;
    cnt_n    = cnt_r;
    grnt_n   = Grnt_;
    owner_n  = Owner;
    err_n    = HoldErr;
    err_id_n = HoldErrId;
    excl     = '0;

    // While granted, the owner never competes in its own handover.
    if (state_r == BUS_ARB_STATE_GRANT) begin
      excl[Owner] = 1'b1;
    end

    if (state_r == BUS_ARB_STATE_GRANT && owner_req) begin
      // Holding: count toward the limit; the grant itself is never revoked.
      if (cnt_r != HOLD_LIM) begin
        cnt_n = cnt_r + 16'd1;
        if ((cnt_r + 16'd1 == HOLD_LIM) && !HoldErr) begin
          err_n    = 1'b1;
          err_id_n = Owner;
        end
      end
    end else if (pick_found) begin
      // Fresh grant from IDLE or direct handover on release.
      grnt_n           = {MASTER_CNT{DISABLE_}};
      grnt_n[pick_idx] = ENABLE_;
      owner_n          = pick_idx;
      ptr_n            = pick_idx + OWNER_W'(1);
      cnt_n            = '0;
      state_n          = BUS_ARB_STATE_GRANT;
    end else begin
      // Nobody waiting: drop the bus, Owner keeps the last grantee.
      grnt_n  = {MASTER_CNT{DISABLE_}};
      state_n = BUS_ARB_STATE_IDLE;
    end

    busy_n = ~&grnt_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= BUS_ARB_STATE_IDLE;
      ptr_r     <= '0;
      cnt_r     <= '0;
      Grnt_     <= {MASTER_CNT{DISABLE_}};
      Owner     <= '0;
      BusBusy   <= 1'b0;
      HoldErr   <= 1'b0;
      HoldErrId <= '0;
    end else begin
      state_r   <= state_n;
      ptr_r     <= ptr_n;
      cnt_r     <= cnt_n;
      Grnt_     <= grnt_n;
      Owner     <= owner_n;
      BusBusy   <= busy_n;
      HoldErr   <= err_n;
      HoldErrId <= err_id_n;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  typedef struct packed {
    logic [3:0] req;
    logic       rst;
    logic [3:0] grnt;
    logic [1:0] owner;
    logic       busy;
    logic       err;
    logic [1:0] id;
  } row_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Req_;
  logic [3:0] Grnt_;
  logic [1:0] Owner;
  logic       BusBusy;
  logic       HoldErr;
  logic [1:0] HoldErrId;

  int   checks = 0;
  int   errors = 0;
  row_t sbq[$];

  bus_arbiter #(
    .MASTER_CNT (4),
    .OWNER_W    (2),
    .HOLD_MAX   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Req_      (Req_),
    .Grnt_     (Grnt_),
    .Owner     (Owner),
    .BusBusy   (BusBusy),
    .HoldErr   (HoldErr),
    .HoldErrId (HoldErrId)
  );

  always #5 clk = ~clk;

  function automatic row_t mk(input logic [3:0] req, input logic rst,
                              input logic [3:0] grnt, input logic [1:0] owner,
                              input logic busy, input logic err,
                              input logic [1:0] id);
    row_t r;
    r.req = req; r.rst = rst; r.grnt = grnt; r.owner = owner;
    r.busy = busy; r.err = err; r.id = id;
    return r;
  endfunction

  // Drive one cycle of stimulus, queue what the arbiter must show after the
  // edge, then move to just after that edge.
  task automatic apply(input row_t r);
    reset = r.rst;
    Req_  = r.req;
    sbq.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t r[$];
    row_t e;
    r.push_back(mk(4'b1111, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 2'd0));
    r.push_back(mk(4'b0000, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 2'd0));
    r.push_back(mk(4'b0000, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 2'd0));
    foreach (r[i]) begin
      apply(r[i]);
      e = sbq.pop_front();
      checks++;
      if ({Grnt_, Owner, BusBusy, HoldErr, HoldErrId} !== {e.grnt, e.owner, e.busy, e.err, e.id}) begin
        errors++;
        $display("FAIL reset step %0d: got Grnt_=%b Owner=%0d BusBusy=%b HoldErr=%b HoldErrId=%0d, want Grnt_=%b Owner=%0d BusBusy=%b HoldErr=%b HoldErrId=%0d",
                 i, Grnt_, Owner, BusBusy, HoldErr, HoldErrId, e.grnt, e.owner, e.busy, e.err, e.id);
      end
    end
  endtask

  // Master 1 alone; holding past edge 4 also crosses the limit of 4.
  task automatic test_single();
    row_t r[$];
    row_t e;
    r.push_back(mk(4'b1111, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 2'd0));
    r.push_back(mk(4'b1101, 1'b0, 4'b1101, 2'd1, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b1101, 1'b0, 4'b1101, 2'd1, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b1101, 1'b0, 4'b1101, 2'd1, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b1101, 1'b0, 4'b1101, 2'd1, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b1101, 1'b0, 4'b1101, 2'd1, 1'b1, 1'b1, 2'd1));
    r.push_back(mk(4'b1111, 1'b0, 4'b1111, 2'd1, 1'b0, 1'b1, 2'd1));
    r.push_back(mk(4'b1111, 1'b0, 4'b1111, 2'd1, 1'b0, 1'b1, 2'd1));
    foreach (r[i]) begin
      apply(r[i]);
      e = sbq.pop_front();
      checks++;
      if ({Grnt_, Owner, BusBusy, HoldErr, HoldErrId} !== {e.grnt, e.owner, e.busy, e.err, e.id}) begin
        errors++;
        $display("FAIL single step %0d: got Grnt_=%b Owner=%0d BusBusy=%b HoldErr=%b HoldErrId=%0d, want Grnt_=%b Owner=%0d BusBusy=%b HoldErr=%b HoldErrId=%0d",
                 i, Grnt_, Owner, BusBusy, HoldErr, HoldErrId, e.grnt, e.owner, e.busy, e.err, e.id);
      end
    end
  endtask

  task automatic test_rotate();
    row_t r[$];
    row_t e;
    r.push_back(mk(4'b1111, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 2'd0));
    r.push_back(mk(4'b0000, 1'b0, 4'b1110, 2'd0, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b0000, 1'b0, 4'b1110, 2'd0, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b0001, 1'b0, 4'b1101, 2'd1, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b0000, 1'b0, 4'b1101, 2'd1, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b0010, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b0000, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b0100, 1'b0, 4'b0111, 2'd3, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b0000, 1'b0, 4'b0111, 2'd3, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b1000, 1'b0, 4'b1110, 2'd0, 1'b1, 1'b0, 2'd0));
    foreach (r[i]) begin
      apply(r[i]);
      e = sbq.pop_front();
      checks++;
      if ({Grnt_, Owner, BusBusy, HoldErr, HoldErrId} !== {e.grnt, e.owner, e.busy, e.err, e.id}) begin
        errors++;
        $display("FAIL rotate step %0d: got Grnt_=%b Owner=%0d BusBusy=%b HoldErr=%b HoldErrId=%0d, want Grnt_=%b Owner=%0d BusBusy=%b HoldErr=%b HoldErrId=%0d",
                 i, Grnt_, Owner, BusBusy, HoldErr, HoldErrId, e.grnt, e.owner, e.busy, e.err, e.id);
      end
    end
  endtask

  // Master 2 owns; master 0 asks mid-grant; on release 3 is ahead of 0.
  task automatic test_handover();
    row_t r[$];
    row_t e;
    r.push_back(mk(4'b1111, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 2'd0));
    r.push_back(mk(4'b1011, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b1010, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b0110, 1'b0, 4'b0111, 2'd3, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b1110, 1'b0, 4'b1110, 2'd0, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b1111, 1'b0, 4'b1111, 2'd0, 1'b0, 1'b0, 2'd0));
    foreach (r[i]) begin
      apply(r[i]);
      e = sbq.pop_front();
      checks++;
      if ({Grnt_, Owner, BusBusy, HoldErr, HoldErrId} !== {e.grnt, e.owner, e.busy, e.err, e.id}) begin
        errors++;
        $display("FAIL handover step %0d: got Grnt_=%b Owner=%0d BusBusy=%b HoldErr=%b HoldErrId=%0d, want Grnt_=%b Owner=%0d BusBusy=%b HoldErr=%b HoldErrId=%0d",
                 i, Grnt_, Owner, BusBusy, HoldErr, HoldErrId, e.grnt, e.owner, e.busy, e.err, e.id);
      end
    end
  endtask

  // Master 3 holds 10 cycles (flag at the 4th), then master 1 overruns too.
  task automatic test_hold();
    row_t r[$];
    row_t e;
    r.push_back(mk(4'b1111, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 2'd0));
    r.push_back(mk(4'b0111, 1'b0, 4'b0111, 2'd3, 1'b1, 1'b0, 2'd0));
    for (int k = 1; k <= 3; k++)
      r.push_back(mk(4'b0111, 1'b0, 4'b0111, 2'd3, 1'b1, 1'b0, 2'd0));
    for (int k = 4; k <= 9; k++)
      r.push_back(mk(4'b0111, 1'b0, 4'b0111, 2'd3, 1'b1, 1'b1, 2'd3));
    r.push_back(mk(4'b1111, 1'b0, 4'b1111, 2'd3, 1'b0, 1'b1, 2'd3));
    r.push_back(mk(4'b1101, 1'b0, 4'b1101, 2'd1, 1'b1, 1'b1, 2'd3));
    for (int k = 1; k <= 5; k++)
      r.push_back(mk(4'b1101, 1'b0, 4'b1101, 2'd1, 1'b1, 1'b1, 2'd3));
    r.push_back(mk(4'b1111, 1'b0, 4'b1111, 2'd1, 1'b0, 1'b1, 2'd3));
    foreach (r[i]) begin
      apply(r[i]);
      e = sbq.pop_front();
      checks++;
      if ({Grnt_, Owner, BusBusy, HoldErr, HoldErrId} !== {e.grnt, e.owner, e.busy, e.err, e.id}) begin
        errors++;
        $display("FAIL hold step %0d: got Grnt_=%b Owner=%0d BusBusy=%b HoldErr=%b HoldErrId=%0d, want Grnt_=%b Owner=%0d BusBusy=%b HoldErr=%b HoldErrId=%0d",
                 i, Grnt_, Owner, BusBusy, HoldErr, HoldErrId, e.grnt, e.owner, e.busy, e.err, e.id);
      end
    end
  endtask

  // Reset during master 2's grant; pointer must return to 0 (master 0 wins).
  task automatic test_reset_mid();
    row_t r[$];
    row_t e;
    r.push_back(mk(4'b1111, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 2'd0));
    r.push_back(mk(4'b1011, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b1011, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b1011, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 2'd0));
    r.push_back(mk(4'b0000, 1'b0, 4'b1110, 2'd0, 1'b1, 1'b0, 2'd0));
    r.push_back(mk(4'b1111, 1'b0, 4'b1111, 2'd0, 1'b0, 1'b0, 2'd0));
    foreach (r[i]) begin
      apply(r[i]);
      e = sbq.pop_front();
      checks++;
      if ({Grnt_, Owner, BusBusy, HoldErr, HoldErrId} !== {e.grnt, e.owner, e.busy, e.err, e.id}) begin
        errors++;
        $display("FAIL reset_mid step %0d: got Grnt_=%b Owner=%0d BusBusy=%b HoldErr=%b HoldErrId=%0d, want Grnt_=%b Owner=%0d BusBusy=%b HoldErr=%b HoldErrId=%0d",
                 i, Grnt_, Owner, BusBusy, HoldErr, HoldErrId, e.grnt, e.owner, e.busy, e.err, e.id);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    Req_  = 4'b1111;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_rotate();
    test_handover();
    test_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the shared system bus. Each bus master's interface raises an active-low request and waits for an active-low grant before driving address strobe. The arbiter grants one master at a time, holds the grant until that master drops its request, then hands the bus to the next requester in rotating order. It also exports the owner index for the bus address/data multiplexer and flags masters that hold the bus too long.

## Interface
- `MASTER_CNT`, default 4: number of masters; power of two, 2..8.
- `OWNER_W`, default 2: owner index width, equal to clog2(`MASTER_CNT`).
- `HOLD_MAX`, default 255: hold-cycle limit before `HoldErr` is raised; 1..65535.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset; sampled on `clk` rising edge.
- `Req_`  in  `MASTER_CNT`  per-master bus request, active low.
- `Grnt_`  out  `MASTER_CNT`  per-master grant, active low, registered, at most one bit low.
- `Owner`  out  `OWNER_W`  index of the current or most recent grantee, registered; drives the bus mux select.
- `BusBusy`  out  1  high while any grant is asserted.
- `HoldErr`  out  1  sticky; set when a grant lasts `HOLD_MAX` cycles.
- `HoldErrId`  out  `OWNER_W`  index of the first master that triggered `HoldErr`.

## Operation
- States: IDLE (no grant) and GRANT (exactly one grant low).
- Reset values: all `Grnt_` = 1, `Owner` = 0, `BusBusy` = 0, `HoldErr` = 0, `HoldErrId` = 0, rotate pointer = 0, hold counter = 0, state = IDLE.
- Pick rule: choose the first index i with `Req_[i]`=0, searching from the pointer upward with wrap-around modulo `MASTER_CNT`.
- IDLE: if any request is low, grant the pick, set `Owner`, set pointer = pick+1 (wrapped), clear the hold counter, and go to GRANT. Otherwise stay in IDLE.
- GRANT, owner's `Req_` still low: keep the grant and increment the hold counter, saturating at `HOLD_MAX`.
- On the cycle the counter reaches `HOLD_MAX`: if `HoldErr` is 0, set it and load `HoldErrId` = `Owner`. The grant is never revoked by the arbiter.
- GRANT, owner's `Req_` high (release): on the same edge, pick among the other requesters using the updated pointer.
  - If a requester exists, grant it directly, update `Owner`/pointer, and clear the counter. There is no idle cycle in this handover.
  - If no requester exists, deassert all grants and go to IDLE. `Owner` keeps its last value.
- A master that releases and re-requests on the same cycle it is seen released competes normally. Because the pointer has moved past it, it has lowest priority.
- Requests from non-owners during GRANT are ignored until release. Non-owner request changes never disturb the current grant.
- `reset` asserted in any state returns every register to its reset value on that edge, even mid-transfer.

## Timing
- Grant latency: a request sampled low at edge N with the arbiter in IDLE gives `Grnt_` low after edge N. That is one cycle.
- Release: owner `Req_` sampled high at edge N gives the old grant high and, if applicable, the new grant low, both after edge N.
- `BusBusy` equals the OR of the inverted `Grnt_` bits, registered together with `Grnt_`.
- `HoldErr` rises on the edge where the counter transitions to `HOLD_MAX`. This is `HOLD_MAX` cycles after the grant edge.
- There is no combinational path from inputs to outputs.

## Structure
- Shared bus header additions:
  - `BUS_MASTER_CNT`
  - `BUS_OWNER_BUS`
  - arbiter state encodings `BUS_ARB_STATE_IDLE` and `BUS_ARB_STATE_GRANT`
  - reuse of the existing `ENABLE_`/`DISABLE_` macros
- Sub-module `bus_arb_rr_pick`: combinational rotating-priority picker. Inputs are the request vector, the pointer, and an exclude mask. Outputs are `found` and `index`.
- The top level holds the FSM, pointer, hold counter and error registers.

## Test plan
- Reset with all `Req_`=1111 → `Grnt_`=1111, `Owner`=0, `BusBusy`=0, `HoldErr`=0. Hold `reset` high while `Req_`=0000 → grants stay 1111.
- `Req_`=1101 (master 1) at edge 0 → `Grnt_`=1101 and `Owner`=1 after edge 0; release at edge 5 → `Grnt_`=1111 and `BusBusy`=0 after edge 5.
- `Req_`=0000 held, each owner releasing 2 cycles after its grant and re-requesting the next cycle → grant order 0,1,2,3,0 with no idle cycle between owners.
- Master 2 granted, master 0 requests mid-grant, master 2 releases with master 3 also requesting → grant goes to 3, then to 0.
- `HOLD_MAX`=4, master 3 held 10 cycles → `HoldErr`=1 and `HoldErrId`=3 at cycle 4. A later overrun by master 1 leaves `HoldErrId`=3.
- Assert `reset` while master 2 is granted → `Grnt_`=1111, `Owner`=0 and pointer 0 next cycle. A following `Req_`=0000 grants master 0.
